// File: rtl/mem_burst_ctrl.sv
// Burst memory controller: turns one command into a run of single-word
// memory accesses, with write-data and read-data handshakes per word.
module mem_burst_ctrl #(
  parameter int WIDTH     = 16,
  parameter int DEPTH     = 64,
  parameter int ADDR_SIZE = $clog2(DEPTH)
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic                 cmd_valid_i,
  output logic                 cmd_ready_o,
  input  logic                 cmd_wr_rd_i,
  input  logic [ADDR_SIZE-1:0] cmd_addr_i,
  input  logic [ADDR_SIZE-1:0] cmd_len_i,
  input  logic                 wr_valid_i,
  output logic                 wr_ready_o,
  input  logic [WIDTH-1:0]     wr_data_i,
  output logic                 rd_valid_o,
  input  logic                 rd_ready_i,
  output logic [WIDTH-1:0]     rd_data_o,
  output logic                 mem_valid_o,
  output logic                 mem_wr_rd_o,
  output logic [ADDR_SIZE-1:0] mem_addr_o,
  output logic [WIDTH-1:0]     mem_wdata_o,
  input  logic                 mem_ready_i,
  input  logic [WIDTH-1:0]     mem_rdata_i,
  output logic                 busy_o,
  output logic                 done_o
);

  localparam logic [2:0] IDLE  = 3'd0;
  localparam logic [2:0] FETCH = 3'd1;
  localparam logic [2:0] ISSUE = 3'd2;
  localparam logic [2:0] WAIT  = 3'd3;
  localparam logic [2:0] HOLD  = 3'd4;

  localparam logic [ADDR_SIZE-1:0] LAST_ADDR = ADDR_SIZE'(DEPTH - 1);

  logic [2:0]           state;
  logic [2:0]           state_nxt;
  logic [2:0]           adv_state;
  logic [ADDR_SIZE-1:0] addr;
  logic [ADDR_SIZE-1:0] addr_inc;
  logic [ADDR_SIZE-1:0] len_cnt;
  logic                 dir;
  logic                 is_idle;
  logic                 is_fetch;
  logic                 is_issue;
  logic                 is_wait;
  logic                 is_hold;
  logic                 cmd_acc;
  logic                 wr_acc;
  logic                 mem_ack;
  logic                 rd_cap;
  logic                 rd_acc;
  logic                 adv;
  logic                 last;

  assign is_idle  = (state == IDLE);
  assign is_fetch = (state == FETCH);
  assign is_issue = (state == ISSUE);
  assign is_wait  = (state == WAIT);
  assign is_hold  = (state == HOLD);

  // cmd_ready is gated by reset so it reads 0 on every reset edge
  // yet rises as soon as reset is released.
  assign cmd_ready_o = is_idle & ~rst_i;
  assign wr_ready_o  = is_fetch;
  assign mem_valid_o = is_issue;
  assign busy_o      = ~is_idle;
  assign mem_addr_o  = addr;
  assign mem_wr_rd_o = dir;

  assign cmd_acc = cmd_ready_o & cmd_valid_i;
  assign wr_acc  = is_fetch & wr_valid_i;
  assign mem_ack = is_wait & mem_ready_i;
  assign rd_cap  = mem_ack & ~dir;
  assign rd_acc  = is_hold & rd_ready_i;
  assign adv     = (mem_ack & dir) | rd_acc;
  assign last    = (len_cnt == '0);

  // DEPTH need not be a power of two, so wrap explicitly.
  assign addr_inc = (addr == LAST_ADDR) ? '0 : addr + 1'b1;

  // Where the burst goes after a word completes.
  always_comb begin
    adv_state = IDLE;
    if (!last) begin
      adv_state = dir ? FETCH : ISSUE;
    end
  end

  // Next-state decode.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: begin
        if (cmd_valid_i) begin
          state_nxt = cmd_wr_rd_i ? FETCH : ISSUE;
        end
      end
      FETCH: begin
        if (wr_valid_i) begin
          state_nxt = ISSUE;
        end
      end
      ISSUE: begin
        state_nxt = WAIT;
      end
      WAIT: begin
        if (mem_ready_i) begin
          state_nxt = dir ? adv_state : HOLD;
        end
      end
      HOLD: begin
        if (rd_ready_i) begin
          state_nxt = adv_state;
        end
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

  // State register.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Burst context: address, remaining length, direction.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      addr    <= '0;
      len_cnt <= '0;
      dir     <= 1'b0;
    end else if (cmd_acc) begin
      addr    <= cmd_addr_i;
      len_cnt <= cmd_len_i;
      dir     <= cmd_wr_rd_i;
    end else if (adv && !last) begin
      addr    <= addr_inc;
      len_cnt <= len_cnt - 1'b1;
    end
  end

  // Write word capture from the producer handshake.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      mem_wdata_o <= '0;
    end else if (wr_acc) begin
      mem_wdata_o <= wr_data_i;
    end
  end

  // Read word capture and hold until the consumer takes it.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      rd_valid_o <= 1'b0;
      rd_data_o  <= '0;
    end else if (rd_cap) begin
      rd_valid_o <= 1'b1;
      rd_data_o  <= mem_rdata_i;
    end else if (rd_acc) begin
      rd_valid_o <= 1'b0;
    end
  end

  // Completion pulse, lands in the first IDLE cycle.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      done_o <= 1'b0;
    end else begin
      done_o <= adv & last;
    end
  end

endmodule

// File: tb/tb_mem_burst_ctrl.sv
// Directed bench for mem_burst_ctrl with a one-cycle-latency memory model.
// Vector table for whole bursts plus hand-written corner sequences.
module tb_mem_burst_ctrl;

  localparam int LIM = 40;

  logic        clk = 1'b0;
  logic        rst_i;
  logic        cmd_valid_i;
  logic        cmd_ready_o;
  logic        cmd_wr_rd_i;
  logic [5:0]  cmd_addr_i;
  logic [5:0]  cmd_len_i;
  logic        wr_valid_i;
  logic        wr_ready_o;
  logic [15:0] wr_data_i;
  logic        rd_valid_o;
  logic        rd_ready_i;
  logic [15:0] rd_data_o;
  logic        mem_valid_o;
  logic        mem_wr_rd_o;
  logic [5:0]  mem_addr_o;
  logic [15:0] mem_wdata_o;
  logic        mem_ready_i;
  logic [15:0] mem_rdata_i;
  logic        busy_o;
  logic        done_o;

  always #5 clk = ~clk;

  mem_burst_ctrl #(.WIDTH(16), .DEPTH(64)) dut (
    .clk_i       (clk),
    .rst_i       (rst_i),
    .cmd_valid_i (cmd_valid_i),
    .cmd_ready_o (cmd_ready_o),
    .cmd_wr_rd_i (cmd_wr_rd_i),
    .cmd_addr_i  (cmd_addr_i),
    .cmd_len_i   (cmd_len_i),
    .wr_valid_i  (wr_valid_i),
    .wr_ready_o  (wr_ready_o),
    .wr_data_i   (wr_data_i),
    .rd_valid_o  (rd_valid_o),
    .rd_ready_i  (rd_ready_i),
    .rd_data_o   (rd_data_o),
    .mem_valid_o (mem_valid_o),
    .mem_wr_rd_o (mem_wr_rd_o),
    .mem_addr_o  (mem_addr_o),
    .mem_wdata_o (mem_wdata_o),
    .mem_ready_i (mem_ready_i),
    .mem_rdata_i (mem_rdata_i),
    .busy_o      (busy_o),
    .done_o      (done_o)
  );

  typedef struct {
    logic             wr;
    logic [5:0]       addr;
    logic [5:0]       len;
    logic [3:0][15:0] words;
  } vec_t;

  vec_t        vecs [4];
  logic [15:0] mem [64];
  logic [6:0]  acc_log [$];
  int          done_cnt = 0;
  int          n_chk = 0;
  int          n_fail = 0;

  // Memory model: acknowledges one cycle after the strobe is sampled.
  always @(posedge clk) begin
    mem_ready_i <= 1'b0;
    if (mem_valid_o) begin
      mem_ready_i <= 1'b1;
      acc_log.push_back({mem_wr_rd_o, mem_addr_o});
      if (mem_wr_rd_o) mem[mem_addr_o] <= mem_wdata_o;
      else mem_rdata_i <= mem[mem_addr_o];
    end
    if (done_o) done_cnt <= done_cnt + 1;
  end

  task automatic chk(input string nm, input logic [63:0] act,
                     input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  function automatic logic [63:0] outs();
    return 64'({cmd_ready_o, wr_ready_o, rd_valid_o, rd_data_o,
                mem_valid_o, mem_wr_rd_o, mem_addr_o, mem_wdata_o,
                busy_o, done_o});
  endfunction

  task automatic wait_wr_ready();
    int n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!wr_ready_o && n < LIM);
    chk("wr_ready_wait", wr_ready_o, 1);
  endtask

  task automatic wait_rd_valid(output int lat);
    lat = 0;
    do begin
      @(negedge clk);
      lat++;
    end while (!rd_valid_o && lat < LIM);
    chk("rd_valid_wait", rd_valid_o, 1);
  endtask

  task automatic do_burst(input vec_t v);
    int base_log;
    int base_done;
    int n;
    int lat;
    logic [5:0] a;
    base_log  = acc_log.size();
    base_done = done_cnt;
    @(negedge clk);
    cmd_valid_i = 1'b1;
    cmd_wr_rd_i = v.wr;
    cmd_addr_i  = v.addr;
    cmd_len_i   = v.len;
    n = 0;
    while (!cmd_ready_o && n < LIM) begin
      @(negedge clk);
      n++;
    end
    chk("cmd_accept", cmd_ready_o, 1);
    @(posedge clk);
    #1 cmd_valid_i = 1'b0;
    for (int i = 0; i <= int'(v.len); i++) begin
      if (v.wr) begin
        wait_wr_ready();
        wr_valid_i = 1'b1;
        wr_data_i  = v.words[i];
        @(posedge clk);
        #1 wr_valid_i = 1'b0;
      end else begin
        wait_rd_valid(lat);
        if (i == 0) chk("first_rd_latency", lat, 3);
        chk("rd_data", rd_data_o, v.words[i]);
        rd_ready_i = 1'b1;
        @(posedge clk);
        #1 rd_ready_i = 1'b0;
      end
    end
    repeat (6) @(negedge clk);
    chk("done_pulses", done_cnt - base_done, 1);
    chk("busy_after", busy_o, 0);
    chk("access_count", acc_log.size() - base_log, int'(v.len) + 1);
    for (int i = 0; i <= int'(v.len); i++) begin
      a = 6'((int'(v.addr) + i) % 64);
      if (base_log + i < acc_log.size())
        chk("access_order", acc_log[base_log + i], {v.wr, a});
      if (v.wr) chk("mem_word", mem[a], v.words[i]);
    end
  endtask

  initial begin
    int n;
    int lat;
    int base_done;
    int bad;
    vec_t v;

    vecs[0] = '{1'b1, 6'd5,  6'd3,
                {16'hA004, 16'hA003, 16'hA002, 16'hA001}};
    vecs[1] = '{1'b0, 6'd5,  6'd3,
                {16'hA004, 16'hA003, 16'hA002, 16'hA001}};
    vecs[2] = '{1'b1, 6'd62, 6'd3,
                {16'hB004, 16'hB003, 16'hB002, 16'hB001}};
    vecs[3] = '{1'b0, 6'd62, 6'd3,
                {16'hB004, 16'hB003, 16'hB002, 16'hB001}};

    rst_i       = 1'b1;
    cmd_valid_i = 1'b0;
    cmd_wr_rd_i = 1'b0;
    cmd_addr_i  = '0;
    cmd_len_i   = '0;
    wr_valid_i  = 1'b0;
    wr_data_i   = '0;
    rd_ready_i  = 1'b0;

    // Reset state and release.
    repeat (2) @(posedge clk);
    #1 chk("reset_outputs", outs(), 0);
    rst_i = 1'b0;
    #1 chk("cmd_ready_after_reset", cmd_ready_o, 1);

    // Whole-burst vectors.
    for (int k = 0; k < 4; k++) do_burst(vecs[k]);

    // Read with the consumer stalled for 10 cycles.
    base_done = done_cnt;
    @(negedge clk);
    cmd_valid_i = 1'b1;
    cmd_wr_rd_i = 1'b0;
    cmd_addr_i  = 6'd5;
    cmd_len_i   = 6'd0;
    @(posedge clk);
    #1 cmd_valid_i = 1'b0;
    wait_rd_valid(lat);
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      chk("stall_rd_valid", rd_valid_o, 1);
      chk("stall_rd_data", rd_data_o, 16'hA001);
      chk("stall_mem_valid", mem_valid_o, 0);
    end
    rd_ready_i = 1'b1;
    @(posedge clk);
    #1 rd_ready_i = 1'b0;
    repeat (4) @(negedge clk);
    chk("stall_done", done_cnt - base_done, 1);

    // Command held during a burst is taken only after done.
    base_done = done_cnt;
    @(negedge clk);
    cmd_valid_i = 1'b1;
    cmd_wr_rd_i = 1'b0;
    cmd_addr_i  = 6'd5;
    cmd_len_i   = 6'd1;
    @(posedge clk);
    #1;
    cmd_addr_i = 6'd6;
    cmd_len_i  = 6'd0;
    rd_ready_i = 1'b1;
    n   = 0;
    bad = 0;
    do begin
      @(negedge clk);
      n++;
      if (cmd_ready_o && busy_o) bad++;
    end while (!cmd_ready_o && n < LIM);
    chk("held_cmd_wait_cycles", n, 7);
    chk("held_cmd_ready_busy", bad, 0);
    chk("held_cmd_done_at_accept", done_o, 1);
    @(posedge clk);
    #1 cmd_valid_i = 1'b0;
    wait_rd_valid(lat);
    chk("held_cmd_rd_data", rd_data_o, 16'hA002);
    repeat (4) @(negedge clk);
    rd_ready_i = 1'b0;
    chk("held_cmd_done", done_cnt - base_done, 2);

    // Reset while waiting on memory discards the burst.
    base_done = done_cnt;
    @(negedge clk);
    cmd_valid_i = 1'b1;
    cmd_wr_rd_i = 1'b1;
    cmd_addr_i  = 6'd20;
    cmd_len_i   = 6'd3;
    @(posedge clk);
    #1 cmd_valid_i = 1'b0;
    wait_wr_ready();
    wr_valid_i = 1'b1;
    wr_data_i  = 16'hC001;
    @(posedge clk);
    #1 wr_valid_i = 1'b0;
    @(posedge clk);
    #1 chk("wait_busy", busy_o, 1);
    rst_i = 1'b1;
    @(posedge clk);
    #1 chk("mid_reset_outputs", outs(), 0);
    rst_i = 1'b0;
    #1 chk("mid_reset_cmd_ready", cmd_ready_o, 1);
    repeat (3) @(negedge clk);
    chk("mid_reset_no_done", done_cnt - base_done, 0);
    v = '{1'b0, 6'd5, 6'd0, {16'h0, 16'h0, 16'h0, 16'hA001}};
    do_burst(v);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1);
  end

endmodule
